// File: rtl/fpf_pkg.sv
// Shared definitions for the forbidden-pattern-free (no 010 / 101) TSV code:
// codeword counting helpers and the encoder state enum.
package fpf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } fpf_state_e;

    // Legal completions of m more bits when the next bit is unconstrained
    // (the last run is already two long, or the prefix is a single bit).
    function automatic int fpf_free(input int m);
        int a;
        int b;
        int t;
        a = 1;
        b = 2;
        for (int i = 0; i < 32; i++) begin
            if (i < m) begin
                t = a + b;
                a = b;
                b = t;
            end
        end
        return a;
    endfunction

    function automatic int fpf_ncode(input int w);
        return 2 * fpf_free(w - 1);
    endfunction

    // A prefix ending in two different bits forces the next bit to repeat the last one.
    function automatic int fpf_count(input int rem_len, input logic [1:0] last2,
                                     input logic plen_lt2);
        if (plen_lt2 || (last2[1] == last2[0]))
            return fpf_free(rem_len);
        if (rem_len == 0)
            return 1;
        return fpf_free(rem_len - 1);
    endfunction

endpackage

// File: rtl/fpf_decoder.sv
// Combinational rank decoder: FPF codeword back to its value, plus a legal flag.
module fpf_decoder
    import fpf_pkg::*;
#(
    parameter  int TSV_W  = 4,
    localparam int DATA_W = $clog2(fpf_ncode(TSV_W))
) (
    input  logic [TSV_W-1:0]  code,
    output logic [DATA_W-1:0] value,
    output logic              legal
);

    logic [TSV_W+1:0] pad;

    assign pad = {2'b00, code};

    always_comb begin
        value = '0;
        legal = 1'b1;
        // Every 1 skips over all legal words that carry a 0 in that position.
        for (int i = TSV_W - 1; i >= 0; i--) begin
            if (code[i]) begin
                if (i == TSV_W - 1)
                    value = value + DATA_W'(fpf_count(i, 2'b00, 1'b1));
                else if (!((i <= TSV_W - 3) && (pad[i+2 -: 2] == 2'b01)))
                    value = value + DATA_W'(fpf_count(i, {pad[i+1], 1'b0}, 1'b0));
            end
        end
        for (int i = 0; i <= TSV_W - 3; i++) begin
            if ((pad[i +: 3] == 3'b010) || (pad[i +: 3] == 3'b101))
                legal = 1'b0;
        end
    end

endmodule

// File: rtl/fpf_tsv_encoder.sv
// Serial FPF encoder: one codeword bit decided per cycle, MSB first, with a
// decode-back self check. in_valid/in_ready and out_valid/out_ready transfer on
// a rising edge where both are high; out_valid/out_tsv hold until taken.
module fpf_tsv_encoder
    import fpf_pkg::*;
#(
    parameter  int TSV_W  = 4,
    localparam int NCODE  = fpf_ncode(TSV_W),
    localparam int DATA_W = $clog2(NCODE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TSV_W-1:0]  out_tsv,
    output logic              range_err,
    output logic              chk_err,
    output logic [15:0]       err_count,
    output fpf_state_e        dbg_state
);

    localparam int              IW      = $clog2(TSV_W);
    localparam logic [IW-1:0]   IDX_TOP = IW'(TSV_W - 1);
    localparam logic [DATA_W:0] NCODE_W = (DATA_W + 1)'(NCODE);

    fpf_state_e        state;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] ref_val;
    logic [IW-1:0]     idx;
    logic [TSV_W-2:0]  sr;

    logic              in_ok;
    logic [DATA_W-1:0] cnt;
    logic              bit_val;
    logic [TSV_W-1:0]  next_word;
    logic [DATA_W-1:0] dec_value;
    logic              dec_legal;
    logic              chk_fail;
    logic              range_evt;
    logic              chk_evt;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;

    assign in_ok = {1'b0, in_data} < NCODE_W;

    // Completions if the current bit were 0; zero when a 0 would close a 010.
    always_comb begin
        cnt = '0;
        if (idx == IDX_TOP)
            cnt = DATA_W'(fpf_count(int'(idx), 2'b00, 1'b1));
        else if (!((int'(idx) <= TSV_W - 3) && (sr[1:0] == 2'b01)))
            cnt = DATA_W'(fpf_count(int'(idx), {sr[0], 1'b0}, 1'b0));
    end

    assign bit_val   = rem >= cnt;
    assign next_word = {sr, bit_val};

    fpf_decoder #(.TSV_W(TSV_W)) u_dec (
        .code  (next_word),
        .value (dec_value),
        .legal (dec_legal)
    );

    assign chk_fail  = !dec_legal || (dec_value != ref_val);
    assign range_evt = (state == IDLE) && in_valid && !in_ok;
    assign chk_evt   = (state == ENCODE) && (idx == '0) && chk_fail;
    assign err_inc   = {1'b0, range_evt} + {1'b0, chk_evt};
    assign err_sum   = {1'b0, err_count} + {15'b0, err_inc};
    assign in_ready  = (state == IDLE) && !reset;
    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            ref_val   <= '0;
            idx       <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_tsv   <= '0;
            range_err <= 1'b0;
            chk_err   <= 1'b0;
            err_count <= '0;
        end else begin
            range_err <= 1'b0;
            chk_err   <= 1'b0;
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_ok) begin
                            rem     <= in_data;
                            ref_val <= in_data;
                            idx     <= IDX_TOP;
                            sr      <= '0;
                            state   <= ENCODE;
                        end else begin
                            range_err <= 1'b1;
                        end
                    end
                end
                ENCODE: begin
                    sr <= next_word[TSV_W-2:0];
                    if (bit_val)
                        rem <= rem - cnt;
                    if (idx == '0) begin
                        out_tsv   <= next_word;
                        out_valid <= 1'b1;
                        chk_err   <= chk_fail;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpf_tsv_encoder.md
FPF_TSV_ENCODER -- requirements
Module: fpf_tsv_encoder

Interface
REQ-001 The block SHALL have parameter TSV_W, default 4, giving the TSV bundle width; legal range is 3..16.
REQ-002 The block SHALL derive localparam NCODE = 2*F(TSV_W+1), the count of forbidden-pattern-free codewords, where F(2)=1 and F(3)=2 (10 for TSV_W=4).
REQ-003 The block SHALL derive localparam DATA_W = clog2(NCODE), giving 4 for TSV_W=4.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  input word offered.
REQ-007 in_ready  out  1  block can accept a word.
REQ-008 in_data  in  DATA_W  value to encode.
REQ-009 out_valid  out  1  out_tsv holds a new codeword.
REQ-010 out_ready  in  1  link consumer takes the codeword.
REQ-011 out_tsv  out  TSV_W  TSV line levels.
REQ-012 range_err  out  1  one-cycle pulse when an out-of-range input is accepted.
REQ-013 chk_err  out  1  one-cycle pulse when the self-check fails.
REQ-014 err_count  out  16  saturating count of range_err and chk_err events.

Function
REQ-015 The block SHALL make a codeword legal only if it contains no 010 or 101 in adjacent bits.
REQ-016 The block SHALL map value v to the v-th legal TSV_W-bit word (0-based) in ascending numeric order. For TSV_W=4 the legal words are 0000, 0001, 0011, 0110, 0111, 1000, 1001, 1100, 1110, 1111.
REQ-017 The FSM SHALL have states IDLE, ENCODE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, when in_valid=1 and in_data<NCODE, the block SHALL latch in_data into rem and into ref, set bit index to TSV_W-1, and go to ENCODE.
REQ-019 In IDLE, when in_valid=1 and in_data>=NCODE, the block SHALL consume the word, pulse range_err on the next cycle, increment err_count, stay in IDLE and leave out_tsv unchanged.
REQ-020 In each ENCODE cycle the block SHALL decide one bit, MSB first:
  - c = number of legal completions given the prefix with the current bit set to 0;
  - if rem<c, the bit is 0;
  - otherwise the bit is 1 and rem becomes rem-c.
REQ-021 The block SHALL build the codeword in an internal shift register; out_tsv SHALL NOT change during ENCODE.
REQ-022 After TSV_W ENCODE cycles the block SHALL load out_tsv, assert out_valid and enter DONE; out_valid therefore rises exactly TSV_W edges after the accepting edge.
REQ-023 In DONE, out_valid and out_tsv SHALL hold until out_ready=1. On that edge the block SHALL clear out_valid and go to IDLE, giving a throughput of one word per TSV_W+2 cycles.
REQ-024 Between words out_tsv SHALL hold the last delivered codeword, so the TSVs do not toggle.
REQ-025 On entry to DONE the block SHALL decode the codeword and compare it with ref.
REQ-026 On a decode mismatch, or if the codeword contains a forbidden pattern, the block SHALL pulse chk_err for one cycle and increment err_count; out_valid SHALL still assert.
REQ-027 err_count SHALL saturate at 16'hFFFF.
REQ-028 When range_err and chk_err occur in the same cycle, err_count SHALL increment by 2, saturating.

Reset
REQ-029 While reset=1 the block SHALL be in IDLE with out_valid=0, out_tsv=0, range_err=0, chk_err=0, err_count=0, rem=0 and ref=0.
REQ-030 Reset asserted mid-ENCODE or in DONE SHALL discard the word; no partial codeword SHALL reach out_tsv.
REQ-031 in_ready SHALL be 0 while reset=1 and SHALL be 1 in the first cycle after release.

Structure
REQ-032 A shared package fpf_pkg SHALL hold:
  - the function computing NCODE(TSV_W);
  - the completion-count function N(remaining_len, last_two_bits, prefix_len<2);
  - the state enum.
REQ-033 The combinational rank decoder SHALL be a separate sub-module fpf_decoder (codeword to value, plus a legal flag), so the receiver side can reuse it.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - TSV_W=4, reset then in_data=3, out_ready=1: out_tsv=0110, and out_valid rises 4 edges after acceptance.
  - Exhaustive v=0..9: outputs 0000, 0001, 0011, 0110, 0111, 1000, 1001, 1100, 1110, 1111; chk_err never pulses; err_count=0.
  - in_data=12 with TSV_W=4: range_err pulses one cycle, err_count=1, out_tsv unchanged, in_ready stays 1.
  - out_ready held 0 for 5 cycles after v=9: out_valid and out_tsv=1111 stable, in_ready=0; consumed on the cycle out_ready rises.
  - Reset pulsed 2 cycles after accepting v=5: out_valid=0, out_tsv=0000, and a following v=5 yields 1000.
  - TSV_W=8 with 1000 random in-range words and a random out_ready: every codeword is free of 010/101, decodes to its input, and err_count=0.
